// File: rtl/dmem_preloader_if.sv
// PMIPS data-memory port as seen from the initiator (master) and the memory (slave).
// There is no backpressure: dmemwrite/dmemread qualify the address each cycle; the memory always accepts.
interface dmem_preloader_if;
   logic [15:0] dmemaddr;
   logic [15:0] dmemwdata;
   logic        dmemwrite;
   logic        dmemread;
   logic [15:0] dmemrdata;

   modport master (
      output dmemaddr, dmemwdata, dmemwrite, dmemread,
      input  dmemrdata
   );

   modport slave (
      input  dmemaddr, dmemwdata, dmemwrite, dmemread,
      output dmemrdata
   );
endinterface

// File: rtl/dmem_preloader.sv
// Copies a preload ROM into data memory, reads it back to verify, and holds the CPU in reset
// until the verified image is in place.
module dmem_preloader #(
   parameter int          WORDS     = 16,
   parameter logic [15:0] BASE_ADDR = 16'h0000
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   output logic [15:0]              rom_addr,
   input  logic [15:0]              rom_rdata,
   dmem_preloader_if.master         dmem,
   output logic                     cpu_reset,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [15:0]              err_addr,
   output logic [2:0]               dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WRITE  = 3'd1,
      S_VERIFY = 3'd2,
      S_DONE   = 3'd3,
      S_FAIL   = 3'd4
   } state_t;

   localparam int IDX_W = (WORDS > 65535) ? 17 : 16;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [15:0]      err_addr_q, err_addr_d;
   logic             dmemwrite_q, dmemread_q, busy_q, done_q, error_q, cpu_reset_q;
   logic [15:0]      addr;

   // Address arithmetic is 16-bit so a block crossing 16'hFFFF wraps to 0.
   assign addr = BASE_ADDR + idx_q[15:0];

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      err_addr_d = err_addr_q;
      case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               state_d = S_WRITE;
               idx_d   = '0;
            end
         end
         S_WRITE: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_VERIFY;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end
         S_VERIFY: begin
            // First mismatch ends verification and latches its address.
            if (dmem.dmemrdata != rom_rdata) begin
               state_d    = S_FAIL;
               err_addr_d = addr;
            end else if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         err_addr_q  <= '0;
         dmemwrite_q <= 1'b0;
         dmemread_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         cpu_reset_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         err_addr_q  <= err_addr_d;
         dmemwrite_q <= (state_d == S_WRITE);
         dmemread_q  <= (state_d == S_VERIFY);
         busy_q      <= (state_d == S_WRITE) || (state_d == S_VERIFY);
         done_q      <= (state_d == S_DONE);
         error_q     <= (state_d == S_FAIL);
         cpu_reset_q <= (state_d != S_DONE);
      end
   end

   assign rom_addr       = idx_q[15:0];
   assign dmem.dmemaddr  = addr;
   assign dmem.dmemwdata = dmemwrite_q ? rom_rdata : 16'h0000;
   assign dmem.dmemwrite = dmemwrite_q;
   assign dmem.dmemread  = dmemread_q;
   assign cpu_reset      = cpu_reset_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = error_q;
   assign err_addr       = err_addr_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_dmem_preloader.sv
// Directed bench for dmem_preloader: three instances (16 words at 0, 4 words wrapping at FFFE,
// 1 word) with memory models and scoreboards of expected write/read traffic.
module tb_dmem_preloader;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
   logic corrupt_a = 1'b0;

   always #5 clock = ~clock;

   dmem_preloader_if bus_a ();
   dmem_preloader_if bus_b ();
   dmem_preloader_if bus_c ();

   logic [15:0] rom_addr_a, rom_addr_b, rom_addr_c;
   logic [15:0] rom_rdata_a, rom_rdata_b, rom_rdata_c;
   logic [15:0] err_addr_a, err_addr_b, err_addr_c;
   logic        cpu_reset_a, busy_a, done_a, error_a;
   logic        cpu_reset_b, busy_b, done_b, error_b;
   logic        cpu_reset_c, busy_c, done_c, error_c;
   logic [2:0]  dbg_a, dbg_b, dbg_c;

   logic [15:0] mem_a [0:65535];
   logic [15:0] mem_b [0:65535];
   logic [15:0] mem_c [0:65535];

   logic [31:0] wr_a[$], wr_b[$], wr_c[$];
   logic [15:0] rd_a[$], rd_b[$], rd_c[$];

   int checks = 0;
   int errors = 0;

   dmem_preloader #(.WORDS(16), .BASE_ADDR(16'h0000)) u_a (
      .clock(clock), .reset(reset), .start(start_a),
      .rom_addr(rom_addr_a), .rom_rdata(rom_rdata_a), .dmem(bus_a),
      .cpu_reset(cpu_reset_a), .busy(busy_a), .done(done_a), .error(error_a),
      .err_addr(err_addr_a), .dbg_state(dbg_a)
   );

   dmem_preloader #(.WORDS(4), .BASE_ADDR(16'hFFFE)) u_b (
      .clock(clock), .reset(reset), .start(start_b),
      .rom_addr(rom_addr_b), .rom_rdata(rom_rdata_b), .dmem(bus_b),
      .cpu_reset(cpu_reset_b), .busy(busy_b), .done(done_b), .error(error_b),
      .err_addr(err_addr_b), .dbg_state(dbg_b)
   );

   dmem_preloader #(.WORDS(1), .BASE_ADDR(16'h0040)) u_c (
      .clock(clock), .reset(reset), .start(start_c),
      .rom_addr(rom_addr_c), .rom_rdata(rom_rdata_c), .dmem(bus_c),
      .cpu_reset(cpu_reset_c), .busy(busy_c), .done(done_c), .error(error_c),
      .err_addr(err_addr_c), .dbg_state(dbg_c)
   );

   // ROM images and memory models
   assign rom_rdata_a = 16'hA500 + rom_addr_a;
   assign rom_rdata_b = 16'h5A00 + rom_addr_b * 16'd3;
   assign rom_rdata_c = (rom_addr_c == 16'h0000) ? 16'h1234 : 16'hDEAD;

   assign bus_a.dmemrdata = !bus_a.dmemread ? 16'h0000 :
                            (corrupt_a && bus_a.dmemaddr == 16'h0005) ? 16'h0000 : mem_a[bus_a.dmemaddr];
   assign bus_b.dmemrdata = bus_b.dmemread ? mem_b[bus_b.dmemaddr] : 16'h0000;
   assign bus_c.dmemrdata = bus_c.dmemread ? mem_c[bus_c.dmemaddr] : 16'h0000;

   always @(posedge clock) begin
      if (bus_a.dmemwrite) mem_a[bus_a.dmemaddr] <= bus_a.dmemwdata;
      if (bus_b.dmemwrite) mem_b[bus_b.dmemaddr] <= bus_b.dmemwdata;
      if (bus_c.dmemwrite) mem_c[bus_c.dmemaddr] <= bus_c.dmemwdata;
   end

   function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endfunction

   function automatic void unexpected(input string tag, input logic [31:0] obs);
      checks++;
      errors++;
      $error("FAIL %s: observed %0h expected no transfer", tag, obs);
   endfunction

   // Scoreboard pops: each observed bus transfer must match the next expected one
   always @(negedge clock) begin
      if (bus_a.dmemwrite) begin
         if (wr_a.size() == 0) unexpected("a_wr_extra", {bus_a.dmemaddr, bus_a.dmemwdata});
         else check("a_wr", {bus_a.dmemaddr, bus_a.dmemwdata}, wr_a.pop_front());
      end
      if (bus_a.dmemread) begin
         if (rd_a.size() == 0) unexpected("a_rd_extra", {16'h0, bus_a.dmemaddr});
         else check("a_rd", {16'h0, bus_a.dmemaddr}, {16'h0, rd_a.pop_front()});
      end
      if (bus_b.dmemwrite) begin
         if (wr_b.size() == 0) unexpected("b_wr_extra", {bus_b.dmemaddr, bus_b.dmemwdata});
         else check("b_wr", {bus_b.dmemaddr, bus_b.dmemwdata}, wr_b.pop_front());
      end
      if (bus_b.dmemread) begin
         if (rd_b.size() == 0) unexpected("b_rd_extra", {16'h0, bus_b.dmemaddr});
         else check("b_rd", {16'h0, bus_b.dmemaddr}, {16'h0, rd_b.pop_front()});
      end
      if (bus_c.dmemwrite) begin
         if (wr_c.size() == 0) unexpected("c_wr_extra", {bus_c.dmemaddr, bus_c.dmemwdata});
         else check("c_wr", {bus_c.dmemaddr, bus_c.dmemwdata}, wr_c.pop_front());
      end
      if (bus_c.dmemread) begin
         if (rd_c.size() == 0) unexpected("c_rd_extra", {16'h0, bus_c.dmemaddr});
         else check("c_rd", {16'h0, bus_c.dmemaddr}, {16'h0, rd_c.pop_front()});
      end
   end

   // Driver tasks
   task automatic push_a(input int n_rd);
      for (int i = 0; i < 16; i++) wr_a.push_back({16'(i), 16'hA500 + 16'(i)});
      for (int i = 0; i < n_rd; i++) rd_a.push_back(16'(i));
   endtask

   task automatic pulse_start(input int w);
      @(negedge clock);
      case (w)
         0:       start_a = 1'b1;
         1:       start_b = 1'b1;
         default: start_c = 1'b1;
      endcase
      @(negedge clock);
      start_a = 1'b0;
      start_b = 1'b0;
      start_c = 1'b0;
   endtask

   function automatic logic ended(input int w);
      case (w)
         0:       return done_a | error_a;
         1:       return done_b | error_b;
         default: return done_c | error_c;
      endcase
   endfunction

   // Counts negedges after the start edge until done/error or the limit; optionally re-pulses start on a.
   task automatic wait_end(input int w, input int limit, input int glitch, output int n);
      n = 0;
      while (!ended(w) && n < limit) begin
         @(negedge clock);
         n++;
         if (w == 0) start_a = (n == glitch);
      end
      start_a = 1'b0;
   endtask

   initial begin
      int n;

      // Reset values
      #2 reset = 1'b1;
      #10;
      check("rst_flags", {26'h0, cpu_reset_a, busy_a, done_a, error_a, bus_a.dmemwrite, bus_a.dmemread}, 32'h20);
      check("rst_err_addr", {16'h0, err_addr_a}, 32'h0);
      check("rst_addr_data", {bus_a.dmemaddr, bus_a.dmemwdata}, 32'h0);
      check("rst_rom_state", {13'h0, dbg_a, rom_addr_a}, 32'h0);
      @(negedge clock);
      reset = 1'b0;

      // Normal 16-word copy
      push_a(16);
      pulse_start(0);
      wait_end(0, 40, 0, n);
      check("a_latency", n, 32);
      check("a_done_flags", {28'h0, cpu_reset_a, busy_a, done_a, error_a}, 32'h2);
      check("a_queues_empty", wr_a.size() + rd_a.size(), 0);

      // Restart from DONE with a start pulse during write cycle 3 that must be ignored
      push_a(16);
      pulse_start(0);
      check("a_restart_flags", {28'h0, cpu_reset_a, busy_a, done_a, error_a}, 32'hC);
      wait_end(0, 40, 2, n);
      check("a_latency_glitch", n, 32);
      check("a_done2", {31'h0, done_a}, 32'h1);
      check("a_queues_empty2", wr_a.size() + rd_a.size(), 0);

      // Corrupted read at address 5
      corrupt_a = 1'b1;
      push_a(6);
      pulse_start(0);
      wait_end(0, 40, 0, n);
      check("a_fail_latency", n, 22);
      check("a_fail_flags", {28'h0, cpu_reset_a, busy_a, done_a, error_a}, 32'h9);
      check("a_err_addr", {16'h0, err_addr_a}, 32'h5);
      check("a_fail_state", {29'h0, dbg_a}, 32'h4);
      check("a_queues_empty3", wr_a.size() + rd_a.size(), 0);

      // Restart from FAIL, then reset asynchronously at verify idx 7
      corrupt_a = 1'b0;
      push_a(16);
      pulse_start(0);
      check("a_fail_restart", {28'h0, cpu_reset_a, busy_a, done_a, error_a}, 32'hC);
      check("a_err_addr_hold", {16'h0, err_addr_a}, 32'h5);
      wait_end(0, 23, 0, n);
      check("a_verify7", {15'h0, bus_a.dmemread, bus_a.dmemaddr}, 32'h10007);
      #1 reset = 1'b1;
      #1;
      check("a_async_flags", {26'h0, cpu_reset_a, busy_a, done_a, error_a, bus_a.dmemwrite, bus_a.dmemread}, 32'h20);
      check("a_async_err_addr", {16'h0, err_addr_a}, 32'h0);
      check("a_async_state", {13'h0, dbg_a, rom_addr_a}, 32'h0);
      wr_a.delete();
      rd_a.delete();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      push_a(16);
      pulse_start(0);
      wait_end(0, 40, 0, n);
      check("a_after_reset_latency", n, 32);
      check("a_after_reset_done", {28'h0, cpu_reset_a, busy_a, done_a, error_a}, 32'h2);

      // Wrapping 4-word copy at FFFE
      for (int i = 0; i < 4; i++) begin
         logic [15:0] ad;
         ad = 16'hFFFE + 16'(i);
         wr_b.push_back({ad, 16'h5A00 + 16'(i * 3)});
         rd_b.push_back(ad);
      end
      pulse_start(1);
      wait_end(1, 20, 0, n);
      check("b_latency", n, 8);
      check("b_done_flags", {28'h0, cpu_reset_b, busy_b, done_b, error_b}, 32'h2);
      check("b_queues_empty", wr_b.size() + rd_b.size(), 0);

      // Single-word copy
      wr_c.push_back({16'h0040, 16'h1234});
      rd_c.push_back(16'h0040);
      pulse_start(2);
      wait_end(2, 10, 0, n);
      check("c_latency", n, 2);
      check("c_done_flags", {28'h0, cpu_reset_c, busy_c, done_c, error_c}, 32'h2);
      check("c_queues_empty", wr_c.size() + rd_c.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
